router_pkt_parser_p: RTL and testbench

ROUTER_PKT_PARSER_P -- requirements
Module: router_pkt_parser_p

---
 rtl/router_pkt_parser_p.sv | 167 ++++++++++++++++
 tb/tb_router_pkt_parser_p.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_parser_p.sv
// Packet parser: source/dest/size/data/check framing with XOR checksum and FIFO forwarding.
// Optional trusted-source filter enabled by defining ROUTER_TRUSTED_FILTER_EN.
module router_pkt_parser_p #(
  parameter int unsigned   DW  = 8,
  parameter int unsigned   SZW = 3,
  parameter logic [DW-1:0] TS0 = DW'(8'h81),
  parameter logic [DW-1:0] TS1 = DW'(8'h83),
  parameter logic [DW-1:0] TS2 = DW'(8'h87)
) (
  input  logic           clk1,
  input  logic           reset,
  input  logic           packet_valid_i,
  input  logic [DW-1:0]  packet_in,
  input  logic           fifo_full,
  output logic           ready_o,
  output logic [DW-1:0]  data_out,
  output logic           data_valid_o,
  output logic [DW-1:0]  destination,
  output logic [SZW-1:0] dsize_o,
  output logic           trusted_source,
  output logic           crc_checked,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEST = 3'd1,
    S_SIZE = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_DROP = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  data_q, data_d;
  logic           dval_q, dval_d;
  logic [DW-1:0]  dest_q, dest_d;
  logic [SZW-1:0] dsize_q, dsize_d;
  logic [DW-1:0]  csum_q, csum_d;
  logic           trusted_q, trusted_d;
  logic           crc_chk_q, crc_chk_d;
  logic           err_q, err_d;

  logic           accept_c;
  logic           src_match_c;
  logic [SZW-1:0] size_field_c;

`ifdef ROUTER_TRUSTED_FILTER_EN
  assign src_match_c = (packet_in == TS0) || (packet_in == TS1) || (packet_in == TS2);
`else
  logic unused_ts_c;
  assign unused_ts_c = ^{TS0, TS1, TS2};
  assign src_match_c = 1'b1;
`endif

  assign ready_o      = !fifo_full && (state_q != S_DROP);
  assign accept_c     = packet_valid_i && ready_o;
  assign size_field_c = packet_in[SZW-1:0];

  // Next-state and datapath updates; strobes default low each cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dval_d    = 1'b0;
    dest_d    = dest_q;
    dsize_d   = dsize_q;
    csum_d    = csum_q;
    trusted_d = trusted_q;
    crc_chk_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          trusted_d = src_match_c;
          csum_d    = '0;
          state_d   = src_match_c ? S_DEST : S_DROP;
        end
      end
      S_DEST: begin
        if (!packet_valid_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (accept_c) begin
          dest_d  = packet_in;
          state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        if (!packet_valid_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (accept_c) begin
          dsize_d = size_field_c;
          state_d = (size_field_c != '0) ? S_DATA : S_CRC;
        end
      end
      S_DATA: begin
        if (!packet_valid_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (accept_c) begin
          csum_d  = csum_q ^ packet_in;
          dsize_d = dsize_q - SZW'(1);
          if (dsize_q == SZW'(1)) begin
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        if (!packet_valid_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (accept_c) begin
          crc_chk_d = 1'b1;
          err_d     = (packet_in != csum_q);
          state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        if (!packet_valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every accepted byte of a trusted packet goes to the FIFO one cycle later.
    if (accept_c && ((state_q != S_IDLE) || src_match_c)) begin
      data_d = packet_in;
      dval_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      dval_q    <= 1'b0;
      dest_q    <= '0;
      dsize_q   <= '0;
      csum_q    <= '0;
      trusted_q <= 1'b0;
      crc_chk_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dval_q    <= dval_d;
      dest_q    <= dest_d;
      dsize_q   <= dsize_d;
      csum_q    <= csum_d;
      trusted_q <= trusted_d;
      crc_chk_q <= crc_chk_d;
      err_q     <= err_d;
    end
  end

  assign data_out       = data_q;
  assign data_valid_o   = dval_q;
  assign destination    = dest_q;
  assign dsize_o        = dsize_q;
  assign trusted_source = trusted_q;
  assign crc_checked    = crc_chk_q;
  assign err            = err_q;

endmodule

// File: tb/tb_router_pkt_parser_p.sv
// Bench for router_pkt_parser_p: directed framing cases plus random packets vs. a packet-level model.
module tb_router_pkt_parser_p;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       packet_valid_i;
  logic [7:0] packet_in;
  logic       fifo_full;
  logic       ready_o;
  logic [7:0] data_out;
  logic       data_valid_o;
  logic [7:0] destination;
  logic [2:0] dsize_o;
  logic       trusted_source;
  logic       crc_checked;
  logic       err;

  int checks = 0;
  int errors = 0;

  router_pkt_parser_p dut (
    .clk1           (clk1),
    .reset          (reset),
    .packet_valid_i (packet_valid_i),
    .packet_in      (packet_in),
    .fifo_full      (fifo_full),
    .ready_o        (ready_o),
    .data_out       (data_out),
    .data_valid_o   (data_valid_o),
    .destination    (destination),
    .dsize_o        (dsize_o),
    .trusted_source (trusted_source),
    .crc_checked    (crc_checked),
    .err            (err)
  );

  always #5 clk1 = ~clk1;

  // Output monitor: collects forwarded bytes, strobe counts and dsize_o changes.
  logic [7:0] fwd_q[$];
  logic [2:0] ds_q[$];
  logic [2:0] ds_prev = 3'd0;
  int         crc_cnt = 0;
  int         err_cnt = 0;

  always @(negedge clk1) begin
    if (data_valid_o) fwd_q.push_back(data_out);
    if (crc_checked) crc_cnt++;
    if (err) err_cnt++;
    if (dsize_o != ds_prev) begin
      ds_q.push_back(dsize_o);
      ds_prev = dsize_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_trusted(input logic [7:0] src);
`ifdef ROUTER_TRUSTED_FILTER_EN
    return (src == 8'h81) || (src == 8'h83) || (src == 8'h87);
`else
    return 1'b1;
`endif
  endfunction

  // Drives a packet byte-per-accept; stall raises fifo_full at byte index stall_at.
  task automatic send(input logic [7:0] pkt[$], input int stall_at, input int stall_len,
                      output int acc);
    int idx;
    int budget;
    int sl;
    idx    = 0;
    sl     = stall_len;
    budget = pkt.size() + stall_len + 4;
    while (idx < pkt.size() && budget > 0) begin
      @(negedge clk1);
      budget--;
      packet_valid_i = 1'b1;
      packet_in      = pkt[idx];
      if (idx == stall_at && sl > 0) begin
        fifo_full = 1'b1;
        sl--;
      end else begin
        fifo_full = 1'b0;
      end
      #1;
      if (fifo_full) chk("ready_during_full", ready_o, 0);
      if (ready_o) idx++;
    end
    acc = idx;
  endtask

  task automatic gap();
    @(negedge clk1);
    packet_valid_i = 1'b0;
    fifo_full      = 1'b0;
    @(negedge clk1);
    #1;
  endtask

  // Full packet through the DUT, checked against the packet-level model.
  task automatic run_pkt(input string tag, input logic [7:0] pkt[$], input int stall_at,
                         input int stall_len);
    int         f0, c0, e0, acc, n, sz;
    bit         tr;
    logic [7:0] x;
    f0 = fwd_q.size();
    c0 = crc_cnt;
    e0 = err_cnt;
    send(pkt, stall_at, stall_len, acc);
    gap();
    n  = pkt.size();
    tr = is_trusted(pkt[0]);
    sz = int'(pkt[2][2:0]);
    x  = 8'h00;
    for (int i = 0; i < sz; i++) x ^= pkt[3 + i];
    chk({tag, "_trusted"}, trusted_source, tr);
    if (tr) begin
      chk({tag, "_accepted"}, acc, n);
      chk({tag, "_fwd_count"}, fwd_q.size() - f0, n);
      if (fwd_q.size() - f0 == n)
        for (int i = 0; i < n; i++) chk({tag, "_fwd_byte"}, fwd_q[f0 + i], pkt[i]);
      chk({tag, "_crc_checked"}, crc_cnt - c0, 1);
      chk({tag, "_err"}, err_cnt - e0, (pkt[n - 1] != x) ? 1 : 0);
      chk({tag, "_dest"}, destination, pkt[1]);
      chk({tag, "_dsize_end"}, dsize_o, 0);
    end else begin
      chk({tag, "_accepted"}, acc, 1);
      chk({tag, "_fwd_count"}, fwd_q.size() - f0, 0);
      chk({tag, "_crc_checked"}, crc_cnt - c0, 0);
      chk({tag, "_err"}, err_cnt - e0, 0);
    end
  endtask

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] ts_tab[3];
    logic [7:0] x;
    int         acc, d0, e0, c0, f0, sz;

    ts_tab[0] = 8'h81;
    ts_tab[1] = 8'h83;
    ts_tab[2] = 8'h87;

    reset          = 1'b1;
    packet_valid_i = 1'b0;
    packet_in      = 8'h00;
    fifo_full      = 1'b0;
    repeat (2) @(negedge clk1);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_dvalid", data_valid_o, 0);
    chk("rst_dest", destination, 0);
    chk("rst_dsize", dsize_o, 0);
    chk("rst_trusted", trusted_source, 0);
    chk("rst_crc", crc_checked, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready_o, 1);
    @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);

    // Good packet with three data bytes; dsize_o must count 3,2,1,0.
    d0  = ds_q.size();
    pkt = '{8'h81, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_pkt("basic", pkt, -1, 0);
    chk("basic_ds_changes", ds_q.size() - d0, 4);
    if (ds_q.size() - d0 == 4)
      for (int i = 0; i < 4; i++) chk("basic_ds_seq", ds_q[d0 + i], 3 - i);

    // Wrong check byte.
    pkt = '{8'h83, 8'h02, 8'h02, 8'hAA, 8'h55, 8'h00};
    run_pkt("badcrc", pkt, -1, 0);

    // fifo_full for three cycles in the middle of DATA.
    pkt = '{8'h87, 8'h09, 8'h04, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    run_pkt("stall", pkt, 4, 3);

    // Zero-length payload goes straight to the check byte.
    pkt = '{8'h81, 8'h07, 8'h00, 8'h00};
    run_pkt("zero_size", pkt, -1, 0);

`ifdef ROUTER_TRUSTED_FILTER_EN
    // Untrusted source: dropped until packet_valid_i falls.
    f0 = fwd_q.size();
    e0 = err_cnt;
    @(negedge clk1);
    packet_valid_i = 1'b1;
    packet_in      = 8'h42;
    #1;
    chk("drop_ready_src", ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      packet_in = 8'($urandom);
      #1;
      chk("drop_ready_low", ready_o, 0);
      chk("drop_trusted", trusted_source, 0);
    end
    @(negedge clk1);
    packet_valid_i = 1'b0;
    #1;
    chk("drop_ready_still_low", ready_o, 0);
    @(negedge clk1);
    #1;
    chk("drop_ready_back", ready_o, 1);
    chk("drop_fwd_count", fwd_q.size() - f0, 0);
    chk("drop_err", err_cnt - e0, 0);
`else
    pkt = '{8'h42, 8'h01, 8'h01, 8'h5A, 8'h5A};
    run_pkt("any_src", pkt, -1, 0);
`endif

    // Abort in DATA, then a clean packet.
    e0  = err_cnt;
    c0  = crc_cnt;
    pkt = '{8'h81, 8'h05, 8'h03, 8'h11};
    send(pkt, -1, 0, acc);
    gap();
    chk("abort_accepted", acc, 4);
    chk("abort_err", err_cnt - e0, 1);
    chk("abort_crc", crc_cnt - c0, 0);
    pkt = '{8'h81, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    run_pkt("after_abort", pkt, -1, 0);

    // Reset asserted in DATA.
    pkt = '{8'h83, 8'h0C, 8'h03, 8'h11};
    send(pkt, -1, 0, acc);
    e0 = err_cnt;
    @(negedge clk1);
    reset          = 1'b1;
    packet_valid_i = 1'b0;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_dest", destination, 0);
    chk("mid_rst_dsize", dsize_o, 0);
    chk("mid_rst_trusted", trusted_source, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_ready", ready_o, 1);
    @(negedge clk1);
    reset = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    #1;
    chk("mid_rst_no_err", err_cnt - e0, 0);
    pkt = '{8'h87, 8'h3C, 8'h02, 8'hF0, 8'h0F, 8'hFF};
    run_pkt("after_rst", pkt, -1, 0);

    // Random packets.
    for (int p = 0; p < 40; p++) begin
      pkt = {};
      if ($urandom_range(0, 3) != 0) pkt.push_back(ts_tab[$urandom_range(0, 2)]);
      else pkt.push_back(8'($urandom));
      pkt.push_back(8'($urandom));
      sz = $urandom_range(0, 7);
      pkt.push_back({5'($urandom), 3'(sz)});
      x = 8'h00;
      for (int i = 0; i < sz; i++) begin
        pkt.push_back(8'($urandom));
        x ^= pkt[3 + i];
      end
      pkt.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : x);
      run_pkt("rand", pkt, $urandom_range(0, pkt.size() - 1), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
